masked_mul_scheduler: RTL and testbench
=======================================

MASKED_MUL_SCHEDULER -- requirements
Module: masked_mul_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SHARES, default 2, the number of Boolean shares per operand.
REQ-002 The block SHALL have parameter BIT_WIDTH, default 1, the width of one share (element of T).
REQ-003 The block SHALL have port in_clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port in_reset, input, 1, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port in_req_valid, input, 2, the per-requester request valid.
REQ-006 The block SHALL have port out_req_ready, output, 2, the per-requester grant; transfer occurs when valid&ready.
REQ-007 The block SHALL have port in_req_a, input, 2 x NUM_SHARES x BIT_WIDTH, the operand A shares per requester.
REQ-008 The block SHALL have port in_req_b, input, 2 x NUM_SHARES x BIT_WIDTH, the operand B shares per requester.
REQ-009 The block SHALL have port in_rand, input, 2 x num_quad(NUM_SHARES) x BIT_WIDTH, fresh randomness: low half r, high half p.
REQ-010 The block SHALL have port in_rand_valid, input, 1, the randomness word valid.
REQ-011 The block SHALL have port out_rand_ready, output, 1, randomness accept; transfer occurs when valid&ready.
REQ-012 The block SHALL have port out_c, output, NUM_SHARES x BIT_WIDTH, the result shares.
REQ-013 The block SHALL have port out_id, output, 1, the index of the requester owning out_c.
REQ-014 The block SHALL have port out_valid, output, 1, the result valid.
REQ-015 The block SHALL have port in_ready, input, 1, the result consumer ready; pop occurs when out_valid&in_ready.

Function
REQ-016 The block SHALL share one multiplier instance between two requesters, granting at most one request per cycle.
REQ-017 The arbiter SHALL be round-robin: a priority pointer (reset 0) SHALL point to the other requester after every grant and SHALL be unchanged when there is no grant.
REQ-018 The block SHALL issue a request only when all of the following hold: the request is valid, it wins arbitration, the randomness buffer is full, and fifo_count + inflight < 2.
REQ-019 The randomness buffer SHALL hold one word; out_rand_ready SHALL be 1 when the buffer is empty or is consumed in the same cycle, allowing simultaneous consume and refill.
REQ-020 Each randomness word SHALL be used for exactly one issue and SHALL never be reused.
REQ-021 On issue, the granted a, b and the buffered r, p SHALL drive the multiplier inputs in the same cycle.
REQ-022 When no request is issued, the multiplier a, b, r and p inputs SHALL all be driven to zero.
REQ-023 The inflight flag SHALL be set on the edge ending the issue cycle t; in cycle t+1 the multiplier output SHALL be written with its id into a 2-entry output FIFO, and inflight SHALL clear.
REQ-024 Minimum latency SHALL be 2 cycles: a request issued in cycle t SHALL give out_valid=1 in cycle t+2.
REQ-025 Results SHALL leave the FIFO in issue order.
REQ-026 out_c and out_id SHALL be held stable while out_valid=1 and in_ready=0.
REQ-027 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-028 The issue check SHALL NOT take credit for a pop in the same cycle.
REQ-029 The FIFO read and write pointers SHALL wrap modulo 2.

Reset
REQ-030 Asserting in_reset low SHALL immediately clear the FIFO, fifo_count, inflight, the randomness buffer and the priority pointer, and SHALL drive out_valid=0, out_req_ready=0, out_rand_ready=0, out_c=0 and out_id=0.
REQ-031 A reset mid-operation SHALL discard any in-flight result.
REQ-032 After reset release, the first issue SHALL be possible only once a fresh randomness word has been accepted.

Structure
REQ-033 The shared package SHALL gain the constant MUL_SCHED_FIFO_DEPTH = 2 and a typedef for the requester id; the block SHALL reuse the package function num_quad.
REQ-034 The block SHALL instantiate masked_hpc3_1_mul as its only sub-module; the arbiter, FIFO and buffer SHALL be local logic.

Verification
REQ-035 With NUM_SHARES=2 and BIT_WIDTH=1, requester 0 shall send a=(1,0) and b=(0,1) with a randomness word available; XOR of the out_c shares shall equal 1, out_id=0, and out_valid shall rise 2 cycles after the grant.
REQ-036 Both requesters shall be held valid continuously with randomness always valid and in_ready=1; grants shall alternate 0,1,0,1 and the result ids shall follow the same order.
REQ-037 With in_rand_valid=0 and requests pending, out_req_ready shall stay 0; after a single randomness word, exactly one grant shall occur.
REQ-038 With in_ready=0, 2 results shall be accepted and out_req_ready shall then stay 0; raising in_ready shall pop both results in order and issuing shall resume.
REQ-039 Driving in_reset low while inflight=1 shall make out_valid=0 in the same cycle, and no stale result shall appear after release.
REQ-040 The multiplier inputs shall be checked to be all zero in every cycle without an issue.

Source files
------------

// File: rtl/masked_mul_scheduler_pkg.sv
// Shared constants, types and index helpers for the masked multiplier
// and the scheduler that time-shares it between two requesters.
package masked_mul_scheduler_pkg;

    localparam int MUL_SCHED_FIFO_DEPTH = 2;
    localparam int MUL_SCHED_NUM_REQ    = 2;

    typedef logic [0:0] req_id_t;

    // Number of unordered share pairs (i<j); one r and one p element each.
    function automatic int num_quad(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Flat index of the pair (i,j) with i<j in row-major upper-triangle order.
    function automatic int quad_idx(input int i, input int j, input int n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_mul_scheduler_hpc3.sv
// First-order-style HPC3 masked AND/multiply gadget with one register
// stage: c is valid the cycle after a, b, r and p are presented.
module masked_hpc3_1_mul
    import masked_mul_scheduler_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              b,
    input  logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]    r,
    input  logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]    p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              c
);

    logic [BIT_WIDTH-1:0] term [NUM_SHARES][NUM_SHARES];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_SHARES; gi++) begin : g_row
            for (gj = 0; gj < NUM_SHARES; gj++) begin : g_col
                logic [BIT_WIDTH-1:0] u_next;
                logic [BIT_WIDTH-1:0] v_next;
                logic [BIT_WIDTH-1:0] u_reg;
                logic [BIT_WIDTH-1:0] v_reg;

                if (gi == gj) begin : g_diag
                    assign u_next = a[gi] & b[gi];
                    assign v_next = '0;
                end else begin : g_cross
                    // r and p are shared by (i,j) and (j,i) so they cancel in the share sum.
                    localparam int K = (gi < gj) ? quad_idx(gi, gj, NUM_SHARES)
                                                 : quad_idx(gj, gi, NUM_SHARES);
                    assign u_next = a[gi] & (b[gj] ^ r[K]);
                    assign v_next = (~a[gi] & r[K]) ^ p[K];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        u_reg <= '0;
                        v_reg <= '0;
                    end else begin
                        u_reg <= u_next;
                        v_reg <= v_next;
                    end
                end

                assign term[gi][gj] = u_reg ^ v_reg;
            end
        end
    endgenerate

    always_comb begin
        c = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                c[i] = c[i] ^ term[i][j];
            end
        end
    end

endmodule

// File: rtl/masked_mul_scheduler.sv
// Round-robin scheduler sharing one masked multiplier between two requesters,
// with a one-word randomness buffer and a two-entry ordered result FIFO.
module masked_mul_scheduler
    import masked_mul_scheduler_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1
) (
    input  logic                                           in_clock,
    input  logic                                           in_reset,
    input  logic [MUL_SCHED_NUM_REQ-1:0]                   in_req_valid,
    output logic [MUL_SCHED_NUM_REQ-1:0]                   out_req_ready,
    input  logic [MUL_SCHED_NUM_REQ-1:0][NUM_SHARES*BIT_WIDTH-1:0] in_req_a,
    input  logic [MUL_SCHED_NUM_REQ-1:0][NUM_SHARES*BIT_WIDTH-1:0] in_req_b,
    input  logic [2*num_quad(NUM_SHARES)*BIT_WIDTH-1:0]    in_rand,
    input  logic                                           in_rand_valid,
    output logic                                           out_rand_ready,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]                out_c,
    output logic                                           out_id,
    output logic                                           out_valid,
    input  logic                                           in_ready
);

    localparam int SW = NUM_SHARES * BIT_WIDTH;
    localparam int QW = num_quad(NUM_SHARES) * BIT_WIDTH;
    localparam int RW = 2 * QW;
    localparam int PW = $clog2(MUL_SCHED_FIFO_DEPTH);
    localparam int CW = PW + 1;

    req_id_t               ptr_reg;
    req_id_t               ptr_next;
    logic                  rand_full_reg;
    logic                  rand_full_next;
    logic [RW-1:0]         rand_reg;
    logic [RW-1:0]         rand_next;
    logic                  inflight_reg;
    req_id_t               inflight_id_reg;
    req_id_t               inflight_id_next;

    logic [SW-1:0]         fifo_c_reg  [MUL_SCHED_FIFO_DEPTH];
    req_id_t               fifo_id_reg [MUL_SCHED_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         fifo_count_reg;
    logic [CW-1:0]         fifo_count_next;

    logic                  grant_valid;
    req_id_t               grant_id;
    logic [CW:0]           occupancy;
    logic                  credit_ok;
    logic                  issue;
    logic                  rand_accept;
    logic                  push;
    logic                  pop;

    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]           mul_a;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]           mul_b;
    logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0] mul_r;
    logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0] mul_p;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]           mul_c;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ptr_reg;
        if (in_req_valid[ptr_reg]) begin
            grant_valid = 1'b1;
            grant_id    = ptr_reg;
        end else if (in_req_valid[~ptr_reg]) begin
            grant_valid = 1'b1;
            grant_id    = ~ptr_reg;
        end
    end

    // A pop in this cycle earns no credit; only settled occupancy counts.
    assign occupancy = {1'b0, fifo_count_reg} + {{CW{1'b0}}, inflight_reg};
    assign credit_ok = occupancy < (CW + 1)'(MUL_SCHED_FIFO_DEPTH);
    assign issue     = in_reset & rand_full_reg & credit_ok & grant_valid;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_SCHED_NUM_REQ; gi++) begin : g_ready
            assign out_req_ready[gi] = issue & (grant_id == req_id_t'(gi));
        end
    endgenerate

    assign out_rand_ready = in_reset & (~rand_full_reg | issue);
    assign rand_accept    = in_rand_valid & out_rand_ready;

    assign mul_a = issue ? in_req_a[grant_id]  : '0;
    assign mul_b = issue ? in_req_b[grant_id]  : '0;
    assign mul_r = issue ? rand_reg[QW-1:0]    : '0;
    assign mul_p = issue ? rand_reg[RW-1:QW]   : '0;

    masked_hpc3_1_mul #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_mul (
        .clk   (in_clock),
        .rst_n (in_reset),
        .a     (mul_a),
        .b     (mul_b),
        .r     (mul_r),
        .p     (mul_p),
        .c     (mul_c)
    );

    always_comb begin
        ptr_next         = issue ? ~grant_id : ptr_reg;
        inflight_id_next = issue ? grant_id : inflight_id_reg;
        rand_full_next   = rand_full_reg;
        rand_next        = rand_reg;
        if (rand_accept) begin
            rand_full_next = 1'b1;
            rand_next      = in_rand;
        end else if (issue) begin
            rand_full_next = 1'b0;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            ptr_reg         <= '0;
            rand_full_reg   <= 1'b0;
            rand_reg        <= '0;
            inflight_reg    <= 1'b0;
            inflight_id_reg <= '0;
        end else begin
            ptr_reg         <= ptr_next;
            rand_full_reg   <= rand_full_next;
            rand_reg        <= rand_next;
            inflight_reg    <= issue;
            inflight_id_reg <= inflight_id_next;
        end
    end

    assign push = inflight_reg;
    assign pop  = out_valid & in_ready;

    always_comb begin
        fifo_count_next = fifo_count_reg;
        if (push && !pop) begin
            fifo_count_next = fifo_count_reg + CW'(1);
        end else if (!push && pop) begin
            fifo_count_next = fifo_count_reg - CW'(1);
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            for (int i = 0; i < MUL_SCHED_FIFO_DEPTH; i++) begin
                fifo_c_reg[i]  <= '0;
                fifo_id_reg[i] <= '0;
            end
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                fifo_c_reg[wr_ptr_reg]  <= mul_c;
                fifo_id_reg[wr_ptr_reg] <= inflight_id_reg;
                wr_ptr_reg              <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            fifo_count_reg <= fifo_count_next;
        end
    end

    // Head entry is cleared by reset, so outputs read zero while in reset.
    assign out_valid = (fifo_count_reg != '0);
    assign out_c     = fifo_c_reg[rd_ptr_reg];
    assign out_id    = fifo_id_reg[rd_ptr_reg];

endmodule

// File: tb/tb_masked_mul_scheduler.sv
// Directed bench for masked_mul_scheduler with NUM_SHARES=2, BIT_WIDTH=1.
module tb_masked_mul_scheduler;

    localparam int NS = 2;
    localparam int BW = 1;
    localparam int SW = NS * BW;
    localparam int RW = 2 * BW;

    logic                in_clock = 1'b0;
    logic                in_reset = 1'b0;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][SW-1:0]  req_a;
    logic [1:0][SW-1:0]  req_b;
    logic [RW-1:0]       rand_w;
    logic                rand_valid;
    logic                rand_ready;
    logic [SW-1:0]       c;
    logic                id;
    logic                valid;
    logic                rdy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 in_clock = ~in_clock;

    masked_mul_scheduler #(
        .NUM_SHARES (NS),
        .BIT_WIDTH  (BW)
    ) dut (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_req_valid   (req_valid),
        .out_req_ready  (req_ready),
        .in_req_a       (req_a),
        .in_req_b       (req_b),
        .in_rand        (rand_w),
        .in_rand_valid  (rand_valid),
        .out_rand_ready (rand_ready),
        .out_c          (c),
        .out_id         (id),
        .out_valid      (valid),
        .in_ready       (rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge in_clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        in_reset = 1'b0;
        cyc();
        in_reset = 1'b1;
    endtask

    // Multiplier inputs must be all zero whenever nothing is issued.
    always @(negedge in_clock) begin
        if (in_reset && !dut.issue) begin
            check("mul_idle_zero", {dut.mul_a, dut.mul_b, dut.mul_r, dut.mul_p}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish in time");
    end

    bit gq[$];
    bit oq[$];
    int ng;
    bit gid;
    bit resumed;
    logic [SW-1:0] held_c;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0;
        rand_w = '0; rand_valid = 1'b0; rdy = 1'b0;

        // Reset state
        #2;
        check("rst_valid", valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rand_ready", rand_ready, 0);
        check("rst_c", c, 0);
        check("rst_id", id, 0);
        cyc();
        in_reset = 1'b1;

        // Single multiply from requester 0: a=(1,0), b=(0,1), r=1, p=0
        req_valid = 2'b01; req_a[0] = 2'b01; req_b[0] = 2'b10;
        rand_w = 2'b01; rand_valid = 1'b1; rdy = 1'b1;
        settle();
        check("t1_no_grant_before_rand", req_ready, 0);
        check("t1_rand_ready", rand_ready, 1);
        cyc();
        rand_valid = 1'b0;
        settle();
        check("t1_grant0", req_ready, 2'b01);
        check("t1_mul_a", dut.mul_a, 2'b01);
        check("t1_mul_b", dut.mul_b, 2'b10);
        check("t1_mul_r", dut.mul_r, 1);
        check("t1_mul_p", dut.mul_p, 0);
        check("t1_valid_t0", valid, 0);
        cyc();
        req_valid = 2'b00;
        settle();
        check("t1_valid_t1", valid, 0);
        check("t1_no_regrant", req_ready, 0);
        cyc();
        settle();
        check("t1_valid_t2", valid, 1);
        check("t1_id", id, 0);
        check("t1_c", c, 2'b10);
        check("t1_c_xor", ^c, 1);
        cyc();
        settle();
        check("t1_popped", valid, 0);

        // Round-robin with both requesters busy; req0 computes 1*1, req1 computes 0*1
        do_reset();
        req_valid = 2'b11;
        req_a[0] = 2'b01; req_b[0] = 2'b01;
        req_a[1] = 2'b11; req_b[1] = 2'b10;
        rand_valid = 1'b1; rand_w = 2'b10; rdy = 1'b1;
        settle();
        check("t2_first_idle", req_ready, 0);
        gq.delete(); oq.delete();
        for (int k = 0; k < 14; k++) begin
            cyc();
            rand_w = k[1:0];
            settle();
            check("t2_grant_onehot", $countones(req_ready) <= 1, 1);
            if (req_ready != 2'b00) gq.push_back(req_ready[1]);
            if (valid) begin
                if (oq.size() < gq.size()) begin
                    check("t2_product", ^c, (gq[oq.size()] == 1'b0) ? 1 : 0);
                end
                oq.push_back(id);
            end
        end
        check("t2_grant_count", gq.size() >= 4, 1);
        check("t2_result_count", oq.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) check("t2_grant_order", gq[i], i % 2);
        end
        for (int i = 0; i < oq.size(); i++) begin
            if (i < gq.size()) check("t2_result_order", oq[i], gq[i]);
        end

        // No randomness: no grants; then one word gives exactly one grant
        do_reset();
        rand_valid = 1'b0; req_valid = 2'b11; rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t3_starved", req_ready, 0);
            cyc();
        end
        rand_valid = 1'b1; rand_w = 2'b11;
        settle();
        check("t3_rand_ready", rand_ready, 1);
        check("t3_no_grant_yet", req_ready, 0);
        cyc();
        rand_valid = 1'b0;
        ng = 0; gid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (req_ready != 2'b00) begin
                ng++;
                gid = req_ready[1];
            end
            cyc();
        end
        check("t3_one_grant", ng, 1);
        check("t3_grant_id", gid, 0);

        // Consumer stalled: two results fill the FIFO and issuing stops
        rdy = 1'b0; rand_valid = 1'b1; rand_w = 2'b01;
        gq.delete();
        for (int k = 0; k < 8; k++) begin
            settle();
            if (req_ready != 2'b00) gq.push_back(req_ready[1]);
            cyc();
        end
        check("t4_grant_count", gq.size(), 2);
        if (gq.size() >= 2) begin
            check("t4_grant_a", gq[0], 1);
            check("t4_grant_b", gq[1], 0);
        end
        settle();
        held_c = c;
        for (int k = 0; k < 3; k++) begin
            check("t4_blocked", req_ready, 0);
            check("t4_valid_held", valid, 1);
            check("t4_id_held", id, 1);
            check("t4_c_held", c, held_c);
            cyc();
            settle();
        end
        rdy = 1'b1;
        oq.delete(); resumed = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (valid) begin
                if (oq.size() == 0) check("t4_product_a", ^c, 0);
                if (oq.size() == 1) check("t4_product_b", ^c, 1);
                oq.push_back(id);
            end
            if (req_ready != 2'b00) resumed = 1'b1;
            cyc();
            settle();
        end
        check("t4_pop_count", oq.size() >= 2, 1);
        if (oq.size() >= 2) begin
            check("t4_pop_a", oq[0], 1);
            check("t4_pop_b", oq[1], 0);
        end
        check("t4_resumed", resumed, 1);
        cyc();

        // Reset while a result is in flight and another is queued
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) cyc();
        rdy = 1'b0; req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 8 && ng < 2; k++) begin
            settle();
            if (req_ready != 2'b00) ng++;
            cyc();
        end
        check("t5_two_grants", ng, 2);
        settle();
        check("t5_valid_before", valid, 1);
        check("t5_inflight_before", dut.inflight_reg, 1);
        in_reset = 1'b0;
        #1;
        check("t5_valid_async", valid, 0);
        check("t5_c_async", c, 0);
        check("t5_id_async", id, 0);
        check("t5_req_ready_async", req_ready, 0);
        check("t5_rand_ready_async", rand_ready, 0);
        cyc();
        in_reset = 1'b1;
        req_valid = 2'b00; rand_valid = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t5_no_stale", valid, 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
